backscatter_tx_scheduler: RTL and testbench
===========================================

# backscatter_tx_scheduler

Sequences one tag transmission for the backscatter modulator. The block is armed with a payload length, waits for the excitation-packet detector, and skips the 802.11b preamble/header window. It then pulls payload bits from the bit buffer with a ready/valid handshake and drives the modulator's enable and per-bit codeword-flip controls. It sits between the payload bit buffer / envelope detector and the `modulator` trigger input.

## Interface
Parameters:
- DELAY_CYCLES, 1920: cycles from detect event to first bit (192 µs preamble+header at 10 MHz); 1..65535
- BIT_CYCLES, 40: cycles each tag bit is held; 1..255
- HOLDOFF_CYCLES, 100: guard cycles after a transmission before returning idle; 1..65535

Ports:
- clock  in  1  system clock (10 MHz)
- reset  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle pulse; latches tx_len, starts a transmission request
- tx_len  in  8  number of payload bits to send; 0 means arm is ignored
- abort  in  1  level/pulse; forces return to IDLE
- packet_detect  in  1  raw, asynchronous excitation-packet detector output
- data_valid  in  1  bit buffer has a bit available
- data_bit  in  1  payload bit (1 = flip codeword)
- data_ready  out  1  combinational; high in the cycle a bit is consumed
- mod_enable  out  1  drives modulator trigger_signal
- mod_flip  out  1  current codeword-flip bit to modulator
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on HOLDOFF→IDLE after a transmission
- underrun  out  1  sticky; set on buffer underrun, cleared by next accepted arm

## Operation
- Reset values: state IDLE; mod_enable, mod_flip, data_ready, busy, done, underrun all 0; counters 0.
- packet_detect passes through a 2-flop synchronizer plus a registered previous value. A detect event is a 0→1 transition at the synchronizer output.
- States:
  - IDLE: arm with tx_len≠0 → ARMED. The bit count is latched and underrun is cleared.
  - ARMED: detect event → DELAY. Delay counter loads DELAY_CYCLES.
  - DELAY: counts down. Its last cycle is the first bit boundary.
  - SEND: mod_enable=1. Each bit is held BIT_CYCLES cycles. The last cycle of each bit period is a bit boundary while bits remain.
  - HOLDOFF: mod_enable=0 and mod_flip=0 for HOLDOFF_CYCLES cycles, then → IDLE with done=1 for that one cycle.
- Bit boundary with data_valid=1:
  - data_ready=1 that cycle.
  - At the closing edge: mod_flip←data_bit, mod_enable←1, remaining count decrements, bit counter reloads.
- Bit boundary with data_valid=0:
  - data_ready stays 0.
  - At the closing edge: underrun←1, mod_enable←0, mod_flip←0, state→HOLDOFF.
- When the last bit's period ends, the state → HOLDOFF.
- packet_detect is ignored outside ARMED. A detect already high when ARMED is entered does not trigger; a fresh 0→1 transition is required.
- arm is ignored outside IDLE.
- abort in any state: at the next edge, state→IDLE and mod_enable/mod_flip/data_ready go to 0. done does not pulse; underrun is unchanged.
- abort and arm in the same cycle: abort wins.
- Counters saturate-free: they reload from parameters, with no wrap-around.

## Timing
- arm at cycle t → busy=1 from t+1.
- Raw packet_detect rising before edge e → detect event registered 2 edges later. The DELAY state is entered on the following edge.
- DELAY occupies exactly DELAY_CYCLES cycles. mod_enable rises on the edge ending the last DELAY cycle.
- Each bit holds mod_enable=1 with a constant mod_flip for exactly BIT_CYCLES cycles.
- Total mod_enable high time is tx_len×BIT_CYCLES cycles, contiguous.
- HOLDOFF lasts HOLDOFF_CYCLES cycles. The done pulse coincides with the first IDLE cycle, and busy is 0 in that cycle.
- data_ready is never high in two consecutive cycles when BIT_CYCLES>1. With BIT_CYCLES=1 it may be high every SEND cycle.
- Asynchronous reset takes effect immediately mid-transmission; all outputs go low.

## Test plan
Bench parameters: DELAY_CYCLES=20, BIT_CYCLES=4, HOLDOFF_CYCLES=5, data_valid tied high unless stated.

- Reset: assert reset mid-SEND → mod_enable, data_ready, busy = 0 immediately; state IDLE after release.
- Nominal: arm with tx_len=3, bits 1,0,1, then raise packet_detect.
  - After sync + 20 delay cycles, mod_enable is high 12 cycles with mod_flip 1,0,1 for 4 cycles each.
  - data_ready pulses 3 times.
  - done pulses 5 cycles after mod_enable falls.
- Underrun: tx_len=4, data_valid drops before the 3rd boundary → exactly 2 bits sent (8 cycles), underrun=1, HOLDOFF, then done. Next arm clears underrun.
- Ignored events:
  - arm with tx_len=0 → stays IDLE.
  - packet_detect pulses in IDLE/DELAY/SEND → no effect.
  - packet_detect already high when arm arrives → no start until it falls and rises again.
- Abort: abort during DELAY and again during SEND → IDLE the next cycle, mod_enable=0, no done pulse. A new arm is accepted afterwards.
- Simultaneous: arm+abort in the same cycle → remains IDLE, busy=0.

Source files
------------

// File: rtl/backscatter_tx_scheduler.sv
// backscatter_tx_scheduler
// Sequences one backscatter tag transmission. Once armed with a payload length,
// the block waits for a fresh excitation-packet detect and lets the 802.11b
// preamble/header window pass. It then pulls payload bits from the bit buffer
// and holds each bit on the modulator for a fixed bit period. A guard holdoff
// follows before the block returns to idle.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   arm            one-cycle start request; latches tx_len (ignored unless idle)
//   tx_len         payload length in bits; zero means the arm is ignored
//   abort          forces an immediate return to idle on the next edge
//   packet_detect  raw asynchronous excitation-packet detector output
//   data_valid     bit buffer holds a bit
//   data_bit       payload bit (1 = flip codeword)
//   data_ready     combinational; high in the cycle a bit is consumed
//   mod_enable     modulator trigger
//   mod_flip       codeword-flip control for the current bit
//   busy           high whenever not idle
//   done           one-cycle pulse on the first idle cycle after a holdoff
//   underrun       sticky buffer-underrun flag, cleared by the next accepted arm

module backscatter_tx_scheduler #(
  parameter int unsigned DELAY_CYCLES   = 1920,
  parameter int unsigned BIT_CYCLES     = 40,
  parameter int unsigned HOLDOFF_CYCLES = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm,
  input  logic [7:0] tx_len,
  input  logic       abort,
  input  logic       packet_detect,
  input  logic       data_valid,
  input  logic       data_bit,
  output logic       data_ready,
  output logic       mod_enable,
  output logic       mod_flip,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned DLY_W = 16;
  localparam int unsigned BIT_W = 8;
  localparam int unsigned HLD_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    SEND    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [DLY_W-1:0]   delay_cnt;
  logic [DLY_W-1:0]   delay_cnt_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_cnt_d;
  logic [HLD_W-1:0]   hold_cnt;
  logic [HLD_W-1:0]   hold_cnt_d;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   remaining_d;
  logic               mod_enable_d;
  logic               mod_flip_d;
  logic               busy_d;
  logic               done_d;
  logic               underrun_d;

  logic               sync_meta;
  logic               sync_out;
  logic               sync_prev;
  logic               detect_event;
  logic               at_boundary;

  // Two-flop synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= packet_detect;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
    end
  end

  assign detect_event = sync_out & ~sync_prev;

  // Bit boundary: last DELAY cycle, or last cycle of a bit while bits remain
  assign at_boundary = ((state == DELAY) && (delay_cnt == DLY_W'(1))) ||
                       ((state == SEND) && (bit_cnt == BIT_W'(1)) &&
                        (remaining != LEN_W'(0)));

  assign data_ready = at_boundary & data_valid;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    delay_cnt_d  = delay_cnt;
    bit_cnt_d    = bit_cnt;
    hold_cnt_d   = hold_cnt;
    remaining_d  = remaining;
    mod_enable_d = mod_enable;
    mod_flip_d   = mod_flip;
    done_d       = 1'b0;
    underrun_d   = underrun;

    if (abort) begin
      state_d      = IDLE;
      mod_enable_d = 1'b0;
      mod_flip_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm && (tx_len != LEN_W'(0))) begin
            state_d     = ARMED;
            remaining_d = tx_len;
            underrun_d  = 1'b0;
          end
        end

        ARMED: begin
          if (detect_event) begin
            state_d     = DELAY;
            delay_cnt_d = DLY_W'(DELAY_CYCLES);
          end
        end

        DELAY, SEND: begin
          if (at_boundary) begin
            if (data_valid) begin
              state_d      = SEND;
              mod_enable_d = 1'b1;
              mod_flip_d   = data_bit;
              remaining_d  = remaining - LEN_W'(1);
              bit_cnt_d    = BIT_W'(BIT_CYCLES);
            end else begin
              // Buffer ran dry: stop modulating and go to the guard period
              state_d      = HOLDOFF;
              mod_enable_d = 1'b0;
              mod_flip_d   = 1'b0;
              underrun_d   = 1'b1;
              hold_cnt_d   = HLD_W'(HOLDOFF_CYCLES);
            end
          end else if ((state == SEND) && (bit_cnt == BIT_W'(1))) begin
            // Last bit period has ended
            state_d      = HOLDOFF;
            mod_enable_d = 1'b0;
            mod_flip_d   = 1'b0;
            hold_cnt_d   = HLD_W'(HOLDOFF_CYCLES);
          end else if (state == DELAY) begin
            delay_cnt_d = delay_cnt - DLY_W'(1);
          end else begin
            bit_cnt_d = bit_cnt - BIT_W'(1);
          end
        end

        HOLDOFF: begin
          if (hold_cnt == HLD_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt - HLD_W'(1);
          end
        end

        default: begin
          state_d      = IDLE;
          mod_enable_d = 1'b0;
          mod_flip_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      delay_cnt  <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      remaining  <= '0;
      mod_enable <= 1'b0;
      mod_flip   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      delay_cnt  <= delay_cnt_d;
      bit_cnt    <= bit_cnt_d;
      hold_cnt   <= hold_cnt_d;
      remaining  <= remaining_d;
      mod_enable <= mod_enable_d;
      mod_flip   <= mod_flip_d;
      busy       <= busy_d;
      done       <= done_d;
      underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_backscatter_tx_scheduler.sv
// Testbench for backscatter_tx_scheduler: table of transaction scenarios,
// hand-written corner sequences and randomized transactions, all checked
// cycle by cycle against a timeline model derived from the transaction rules.

module tb_backscatter_tx_scheduler;

  localparam int D = 20;
  localparam int B = 4;
  localparam int H = 5;

  logic       clock;
  logic       reset;
  logic       arm;
  logic [7:0] tx_len;
  logic       abort;
  logic       packet_detect;
  logic       data_valid;
  logic       data_bit;
  logic       data_ready;
  logic       mod_enable;
  logic       mod_flip;
  logic       busy;
  logic       done;
  logic       underrun;

  int   checks = 0;
  int   errors = 0;
  logic ur_model = 1'b0;

  backscatter_tx_scheduler #(
    .DELAY_CYCLES  (D),
    .BIT_CYCLES    (B),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm),
    .tx_len       (tx_len),
    .abort        (abort),
    .packet_detect(packet_detect),
    .data_valid   (data_valid),
    .data_bit     (data_bit),
    .data_ready   (data_ready),
    .mod_enable   (mod_enable),
    .mod_flip     (mod_flip),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int           len;
    logic [255:0] bits;
    int           k;          // bits available before the buffer runs dry
    int           gap;        // cycles from arm to raw detect rise
    int           abort_off;  // abort cycle relative to DELAY entry, -1 none
    int           exp_en;
    int           exp_done;
    logic         exp_ur;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp, input int cyc);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One transaction, checked every cycle against the timeline model
  task automatic run_scn(input int len, input logic [255:0] bits, input int k,
                         input int gap, input int abort_off, input int pd_hold,
                         input bit noise, output int en_cnt, output int dn_cnt,
                         output logic ur_end);
    int a, p, ds, s, sent, h, hd, c, total, j;
    logic e_busy, e_en, e_flip, e_rdy, e_done, e_ur, ur_at_c;
    a     = 2;
    p     = a + gap;
    ds    = p + 3;             // DELAY entered three edges after raw rise
    s     = ds + D;            // first SEND cycle
    sent  = (k < len) ? k : len;
    h     = s + sent * B;      // first HOLDOFF cycle
    hd    = h + H;             // done cycle
    c     = (abort_off < 0) ? 1000000 : ds + abort_off;
    total = hd + 4;
    en_cnt  = 0;
    dn_cnt  = 0;
    ur_at_c = ur_model;
    e_ur    = ur_model;
    for (int n = 0; n < total; n++) begin
      @(negedge clock);
      arm           = (n == a);
      tx_len        = 8'(len);
      abort         = (n == c);
      packet_detect = (n >= p && n < p + pd_hold) ||
                      (noise && ((n >= ds + 3 && n < ds + 5) || (n >= s + 1 && n < s + 3)));
      data_valid    = (k >= len) || (n < s - 1 + k * B);
      j = (n >= s - 1) ? (n - (s - 1)) / B : 0;
      if (j > len - 1) j = len - 1;
      data_bit = bits[j];
      #1;
      e_busy = (n > a) && (n < hd);
      e_en   = (n >= s) && (n < h);
      e_flip = e_en ? bits[(n - s) / B] : 1'b0;
      e_rdy  = (n >= s - 1) && (((n - (s - 1)) % B) == 0) && (((n - (s - 1)) / B) < sent);
      e_done = (n == hd);
      if (n <= a)                 e_ur = ur_model;
      else if (n >= h && k < len) e_ur = 1'b1;
      else                        e_ur = 1'b0;
      if (n > c) begin
        e_busy = 1'b0; e_en = 1'b0; e_flip = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
        e_ur = ur_at_c;
      end else if (n == c) begin
        ur_at_c = e_ur;
      end
      chk("busy", busy, e_busy, n);
      chk("mod_enable", mod_enable, e_en, n);
      chk("mod_flip", mod_flip, e_flip, n);
      chk("data_ready", data_ready, e_rdy, n);
      chk("done", done, e_done, n);
      chk("underrun", underrun, e_ur, n);
      if (mod_enable === 1'b1) en_cnt++;
      if (done === 1'b1) dn_cnt++;
    end
    ur_model = e_ur;
    ur_end   = underrun;
    @(negedge clock);
    arm = 1'b0; abort = 1'b0; packet_detect = 1'b0; data_valid = 1'b1;
  endtask

  vec_t tbl [9];

  initial begin
    int   en_cnt, dn_cnt, len, k, gap, sent, aoff;
    logic ur_end;
    logic [255:0] rbits;
    bit   seen;

    tbl[0] = '{3,   256'b101,  3,   2, -1,        12,   1, 1'b0};
    tbl[1] = '{4,   256'b1011, 2,   1, -1,        8,    1, 1'b1};
    tbl[2] = '{4,   256'b0110, 4,   0, -1,        16,   1, 1'b0};
    tbl[3] = '{1,   256'b1,    0,   3, -1,        0,    1, 1'b1};
    tbl[4] = '{2,   256'b10,   2,   4, 5,         0,    0, 1'b0};
    tbl[5] = '{3,   256'b011,  3,   2, D + 6,     7,    0, 1'b0};
    tbl[6] = '{4,   256'b1001, 1,   1, D + B + 2, 4,    0, 1'b1};
    tbl[7] = '{5,   256'b10110,5,   0, -1,        20,   1, 1'b0};
    tbl[8] = '{255, {8{32'hA5C3_0F96}}, 255, 2, -1, 1020, 1, 1'b0};

    reset = 1'b1; arm = 1'b0; tx_len = 8'd0; abort = 1'b0;
    packet_detect = 1'b0; data_valid = 1'b1; data_bit = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", busy, 1'b0, 0);
    chk("rst_mod_enable", mod_enable, 1'b0, 0);
    chk("rst_mod_flip", mod_flip, 1'b0, 0);
    chk("rst_data_ready", data_ready, 1'b0, 0);
    chk("rst_done", done, 1'b0, 0);
    chk("rst_underrun", underrun, 1'b0, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Table-driven scenarios
    for (int i = 0; i < 9; i++) begin
      run_scn(tbl[i].len, tbl[i].bits, tbl[i].k, tbl[i].gap, tbl[i].abort_off,
              3, 1'b1, en_cnt, dn_cnt, ur_end);
      chk_int($sformatf("tbl%0d_en_cycles", i), en_cnt, tbl[i].exp_en);
      chk_int($sformatf("tbl%0d_done_pulses", i), dn_cnt, tbl[i].exp_done);
      chk($sformatf("tbl%0d_underrun", i), ur_end, tbl[i].exp_ur, 0);
    end

    // arm with tx_len = 0 is ignored, detect pulses in idle have no effect
    @(negedge clock);
    arm = 1'b1; tx_len = 8'd0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      arm = 1'b0;
      packet_detect = (n >= 2 && n < 5);
      #1;
      chk("len0_busy", busy, 1'b0, n);
      chk("len0_mod_enable", mod_enable, 1'b0, n);
    end
    packet_detect = 1'b0;

    // arm and abort together: abort wins
    @(negedge clock);
    arm = 1'b1; tx_len = 8'd3; abort = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      arm = 1'b0; abort = 1'b0;
      packet_detect = (n >= 3 && n < 6);
      #1;
      chk("armabort_busy", busy, 1'b0, n);
    end
    packet_detect = 1'b0;
    repeat (4) @(negedge clock);

    // Detect already high at arm: needs a fresh rise; a second arm is ignored
    packet_detect = 1'b1;
    repeat (5) @(negedge clock);
    arm = 1'b1; tx_len = 8'd2;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      arm = (n == 10);
      tx_len = (n == 10) ? 8'd5 : 8'd2;
      #1;
      chk("prehigh_busy", busy, 1'b1, n);
      chk("prehigh_mod_enable", mod_enable, 1'b0, n);
    end
    @(negedge clock);
    arm = 1'b0; packet_detect = 1'b0;
    repeat (3) @(negedge clock);
    packet_detect = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clock);
      #1;
      if (mod_enable === 1'b1) begin
        seen = 1'b1;
        chk_int("prehigh_first_enable_cycle", i, 3 + D);
      end
    end
    if (!seen) chk_int("prehigh_enable_timeout", 0, 1);
    en_cnt = 1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      packet_detect = 1'b0;
      #1;
      if (mod_enable === 1'b1) en_cnt++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("prehigh_done_seen", seen, 1'b1, 0);
    chk_int("prehigh_en_cycles", en_cnt, 2 * B);
    chk("prehigh_underrun", underrun, 1'b0, 0);
    ur_model = 1'b0;
    repeat (3) @(negedge clock);

    // Asynchronous reset in the middle of SEND
    arm = 1'b1; tx_len = 8'd3; data_bit = 1'b1;
    @(negedge clock);
    arm = 1'b0; packet_detect = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      #1;
      if (mod_enable === 1'b1) seen = 1'b1;
    end
    if (!seen) chk_int("rstmid_enable_timeout", 0, 1);
    repeat (3) @(negedge clock);
    #1;
    chk("rstmid_boundary_ready", data_ready, 1'b1, 0);
    reset = 1'b1;
    #1;
    chk("rstmid_mod_enable", mod_enable, 1'b0, 0);
    chk("rstmid_data_ready", data_ready, 1'b0, 0);
    chk("rstmid_busy", busy, 1'b0, 0);
    chk("rstmid_mod_flip", mod_flip, 1'b0, 0);
    @(negedge clock);
    packet_detect = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      #1;
      chk("rstmid_idle_busy", busy, 1'b0, n);
    end
    ur_model = 1'b0;

    // Randomized transactions
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(1, 10);
      for (int w = 0; w < 8; w++) rbits[w*32 +: 32] = $urandom;
      k    = ($urandom_range(0, 1) == 1) ? len : $urandom_range(0, len);
      gap  = $urandom_range(0, 4);
      sent = (k < len) ? k : len;
      aoff = ($urandom_range(0, 3) == 0) ? $urandom_range(0, D + sent * B + H - 1) : -1;
      run_scn(len, rbits, k, gap, aoff, $urandom_range(1, 10),
              1'($urandom_range(0, 1)), en_cnt, dn_cnt, ur_end);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
